// File: rtl/eth_rxcounters_fsm_pkg.sv
// Shared definitions for the MII receive frame tracker: counter widths,
// default timing constants, state encoding and state bit positions.
package eth_rxcounters_fsm_pkg;

  localparam int unsigned BYTE_CNT_W = 16;
  localparam int unsigned IFG_CNT_W  = 5;
  localparam int unsigned DLY_CNT_W  = 3;

  // 24 idle nibbles = 96 bit times
  localparam logic [IFG_CNT_W-1:0] IFG_MIN_DEF       = 5'h18;
  localparam logic [DLY_CNT_W-1:0] DLY_CRC_BYTES_DEF = 3'h4;

  // Bit positions inside the one-hot state vector
  localparam int unsigned ST_IDLE_BIT  = 0;
  localparam int unsigned ST_DROP_BIT  = 1;
  localparam int unsigned ST_PRE_BIT   = 2;
  localparam int unsigned ST_SFD_BIT   = 3;
  localparam int unsigned ST_DATA0_BIT = 4;
  localparam int unsigned ST_DATA1_BIT = 5;

  // One-hot so every state output is a flop bit
  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_DROP     = 6'b000010,
    ST_PREAMBLE = 6'b000100,
    ST_SFD      = 6'b001000,
    ST_DATA0    = 6'b010000,
    ST_DATA1    = 6'b100000
  } rx_state_t;

  function automatic logic in_data(input rx_state_t s);
    return s[ST_DATA0_BIT] | s[ST_DATA1_BIT];
  endfunction

endpackage

// File: rtl/eth_rxcounters_fsm_rx_statem.sv
// RX frame state machine: Idle/Drop/Preamble/SFD/Data0/Data1.
// Ports:
//   i_clk, i_rst_n          receive clock, async active-low reset
//   i_mrx_dv                MII receive data valid
//   i_mrxd_eq5, i_mrxd_eqd  current nibble is 4'h5 / 4'hD
//   i_transmitting          MAC transmitting (receive is blocked)
//   i_ifg_eq24              inter-frame gap satisfied
//   i_byte_cnt_max_frame    frame has reached its maximum length
//   o_state                 registered one-hot state
//   o_state_next_c          combinational next state for the counters
module eth_rxcounters_fsm_rx_statem
  import eth_rxcounters_fsm_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_mrx_dv,
  input  logic      i_mrxd_eq5,
  input  logic      i_mrxd_eqd,
  input  logic      i_transmitting,
  input  logic      i_ifg_eq24,
  input  logic      i_byte_cnt_max_frame,
  output rx_state_t o_state,
  output rx_state_t o_state_next_c
);

  rx_state_t r_state;
  rx_state_t w_state_next;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_DROP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; loss of data valid overrides everything
  always_comb begin
    w_state_next = r_state;
    if (!i_mrx_dv) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_transmitting)  w_state_next = ST_DROP;
          else if (i_mrxd_eq5) w_state_next = ST_SFD;
          else                 w_state_next = ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (i_mrxd_eq5) w_state_next = ST_SFD;
        end
        ST_SFD: begin
          if (i_mrxd_eqd)      w_state_next = i_ifg_eq24 ? ST_DATA0 : ST_DROP;
          else if (i_mrxd_eq5) w_state_next = ST_SFD;
          else                 w_state_next = ST_PREAMBLE;
        end
        ST_DATA0: begin
          w_state_next = i_byte_cnt_max_frame ? ST_DROP : ST_DATA1;
        end
        ST_DATA1: w_state_next = ST_DATA0;
        ST_DROP:  w_state_next = ST_DROP;
        default:  w_state_next = ST_DROP;
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_state_next_c = w_state_next;

endmodule

// File: rtl/eth_rxcounters_fsm.sv
// Receive-side frame tracker: runs the RX state machine and keeps the byte,
// inter-frame-gap and delayed-CRC counters for the RX datapath.
// Optional feature: define ETH_RX_DLYCRC_EN to build the delayed-CRC skip
// counter; otherwise o_dly_crc_cnt is 0 and i_dly_crc_en is ignored.
// Ports:
//   i_mrx_clk, i_reset_n       receive clock, async active-low reset
//   i_mrx_dv, i_mrxd_eq5/eqd   MII data valid and nibble decodes
//   i_transmitting             MAC transmitting
//   i_r_ifg                    ignore the inter-frame gap check
//   i_max_fl, i_hug_en         maximum frame length and its override
//   i_dly_crc_en               delayed CRC mode
//   o_state_*                  one-hot state (o_state_data[0]=Data0, [1]=Data1)
//   o_byte_cnt                 bytes received in current/last frame
//   o_byte_cnt_eq0_c           byte count is zero
//   o_byte_cnt_max_frame_c     byte count at limit and huge frames disabled
//   o_ifg_counter_eq24_c       gap satisfied or check disabled
//   o_dly_crc_cnt              delayed-CRC skip counter
//   o_rx_end_frm               one-cycle pulse after leaving the data states
module eth_rxcounters_fsm
  import eth_rxcounters_fsm_pkg::*;
#(
  parameter logic [IFG_CNT_W-1:0] IFG_MIN       = IFG_MIN_DEF,
  parameter logic [DLY_CNT_W-1:0] DLY_CRC_BYTES = DLY_CRC_BYTES_DEF
) (
  input  logic                  i_mrx_clk,
  input  logic                  i_reset_n,
  input  logic                  i_mrx_dv,
  input  logic                  i_mrxd_eq5,
  input  logic                  i_mrxd_eqd,
  input  logic                  i_transmitting,
  input  logic                  i_r_ifg,
  input  logic [BYTE_CNT_W-1:0] i_max_fl,
  input  logic                  i_hug_en,
  input  logic                  i_dly_crc_en,
  output logic                  o_state_idle,
  output logic                  o_state_drop,
  output logic                  o_state_preamble,
  output logic                  o_state_sfd,
  output logic [1:0]            o_state_data,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt,
  output logic                  o_byte_cnt_eq0_c,
  output logic                  o_byte_cnt_max_frame_c,
  output logic                  o_ifg_counter_eq24_c,
  output logic [DLY_CNT_W-1:0]  o_dly_crc_cnt,
  output logic                  o_rx_end_frm
);

  rx_state_t w_state;
  rx_state_t w_state_next;

  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [IFG_CNT_W-1:0]  r_ifg_cnt;
  logic                  r_rx_end_frm;
  logic [DLY_CNT_W-1:0]  w_dly_crc_cnt;

  logic w_ifg_eq24;
  logic w_byte_cnt_max_frame;
  logic w_sfd_to_data0;
  logic w_enter_drop;
  logic w_to_idle_or_drop;
  logic w_ifg_count_state;
  logic w_byte_inc;

  assign w_ifg_eq24           = (r_ifg_cnt == IFG_MIN) | i_r_ifg;
  assign w_byte_cnt_max_frame = (r_byte_cnt == i_max_fl) & ~i_hug_en;

  eth_rxcounters_fsm_rx_statem u_rx_statem (
    .i_clk                (i_mrx_clk),
    .i_rst_n              (i_reset_n),
    .i_mrx_dv             (i_mrx_dv),
    .i_mrxd_eq5           (i_mrxd_eq5),
    .i_mrxd_eqd           (i_mrxd_eqd),
    .i_transmitting       (i_transmitting),
    .i_ifg_eq24           (w_ifg_eq24),
    .i_byte_cnt_max_frame (w_byte_cnt_max_frame),
    .o_state              (w_state),
    .o_state_next_c       (w_state_next)
  );

  // Transition qualifiers shared by the counters
  assign w_sfd_to_data0    = (w_state == ST_SFD) && (w_state_next == ST_DATA0);
  assign w_enter_drop      = (w_state != ST_DROP) && (w_state_next == ST_DROP);
  assign w_to_idle_or_drop = (w_state_next == ST_IDLE) || (w_state_next == ST_DROP);
  assign w_ifg_count_state = w_state[ST_IDLE_BIT] | w_state[ST_DROP_BIT] |
                             w_state[ST_PRE_BIT]  | w_state[ST_SFD_BIT];

  // Inter-frame gap counter, saturating at IFG_MIN
  always_ff @(posedge i_mrx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ifg_cnt <= '0;
    end else if (w_sfd_to_data0 || w_enter_drop) begin
      r_ifg_cnt <= '0;
    end else if (w_ifg_count_state && (r_ifg_cnt != IFG_MIN)) begin
      r_ifg_cnt <= r_ifg_cnt + IFG_CNT_W'(1);
    end
  end

  // A byte completes on each high nibble unless still skipping CRC bytes
  assign w_byte_inc = w_state[ST_DATA1_BIT] && i_mrx_dv &&
                      (w_dly_crc_cnt == '0) && (r_byte_cnt != '1);

  // Byte counter; held outside the data phase so the last count stays readable
  always_ff @(posedge i_mrx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_byte_cnt <= '0;
    end else if (w_sfd_to_data0) begin
      r_byte_cnt <= '0;
    end else if (w_byte_inc) begin
      r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
    end
  end

`ifdef ETH_RX_DLYCRC_EN
  logic [DLY_CNT_W-1:0] r_dly_crc_cnt;

  // Counts 1..DLY_CRC_BYTES over the leading bytes, then parks at 0
  always_ff @(posedge i_mrx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dly_crc_cnt <= '0;
    end else if (w_to_idle_or_drop) begin
      r_dly_crc_cnt <= '0;
    end else if (w_sfd_to_data0) begin
      r_dly_crc_cnt <= i_dly_crc_en ? DLY_CNT_W'(1) : '0;
    end else if (w_state[ST_DATA1_BIT] && i_mrx_dv && (r_dly_crc_cnt != '0)) begin
      if (r_dly_crc_cnt == DLY_CRC_BYTES) r_dly_crc_cnt <= '0;
      else                                r_dly_crc_cnt <= r_dly_crc_cnt + DLY_CNT_W'(1);
    end
  end

  assign w_dly_crc_cnt = r_dly_crc_cnt;
`else
  logic w_unused_dly;

  assign w_dly_crc_cnt = '0;
  assign w_unused_dly  = i_dly_crc_en ^ (^DLY_CRC_BYTES);
`endif

  // End-of-frame pulse for the cycle after the data phase ends
  always_ff @(posedge i_mrx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_end_frm <= 1'b0;
    end else begin
      r_rx_end_frm <= in_data(w_state) && w_to_idle_or_drop;
    end
  end

  assign o_state_idle           = w_state[ST_IDLE_BIT];
  assign o_state_drop           = w_state[ST_DROP_BIT];
  assign o_state_preamble       = w_state[ST_PRE_BIT];
  assign o_state_sfd            = w_state[ST_SFD_BIT];
  assign o_state_data           = {w_state[ST_DATA1_BIT], w_state[ST_DATA0_BIT]};
  assign o_byte_cnt             = r_byte_cnt;
  assign o_byte_cnt_eq0_c       = (r_byte_cnt == '0);
  assign o_byte_cnt_max_frame_c = w_byte_cnt_max_frame;
  assign o_ifg_counter_eq24_c   = w_ifg_eq24;
  assign o_dly_crc_cnt          = w_dly_crc_cnt;
  assign o_rx_end_frm           = r_rx_end_frm;

endmodule
